// File: rtl/exec_stall_ctrl.sv
// Stall controller for the single-issue core: sequences multi-cycle ALU ops
// through a start/done handshake with timeout and flush abort, and gates commit via ready.
module exec_stall_ctrl #(
  parameter logic [4:0] OP_MUL  = 5'd8,
  parameter logic [4:0] OP_DIV  = 5'd9,
  parameter logic [4:0] OP_MOD  = 5'd10,
  parameter logic [4:0] OP_POW  = 5'd11,
  parameter logic [4:0] OP_RAD  = 5'd12,
  parameter int         TIMEOUT = 64,
  parameter int         STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [4:0]         opsel,
  input  logic               mem_busy,
  input  logic               flush,
  input  logic               mc_done,
  output logic               ready,
  output logic               mc_start,
  output logic [4:0]         mc_op,
  output logic               mc_cancel,
  output logic               busy,
  output logic               timeout_err,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [4:0]         r_mc_op;
  logic               r_timeout_err;
  logic [STALL_W-1:0] r_stall_cnt;

  logic w_mc_hit;
  logic w_ready;
  logic w_start;
  logic w_cancel;
  logic w_timeout;
  logic w_latch;

  assign w_mc_hit = instr_valid & ((opsel == OP_MUL) | (opsel == OP_DIV) | (opsel == OP_MOD) |
                                   (opsel == OP_POW) | (opsel == OP_RAD));

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_start      = 1'b0;
    w_cancel     = 1'b0;
    w_timeout    = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = instr_valid & ~w_mc_hit & ~mem_busy;
        if (w_mc_hit & ~flush) begin
          w_latch      = 1'b1;
          w_state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (flush) begin
          w_cancel     = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_start      = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_cancel     = 1'b1;
          w_state_next = S_IDLE;
        end else if (mc_done) begin
          w_state_next = S_DONE;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_cancel     = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_ready      = ~flush;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Reset forces every output low, including the combinational ones.
  assign ready       = w_ready & rst;
  assign mc_start    = w_start & rst;
  assign mc_cancel   = w_cancel & rst;
  assign busy        = (r_state != S_IDLE);
  assign mc_op       = r_mc_op;
  assign timeout_err = r_timeout_err;
  assign stall_cnt   = r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_mc_op       <= '0;
      r_timeout_err <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_mc_op <= opsel;
      end
      // Counter only advances while staying in WAIT, so it never wraps.
      if (r_state == S_LAUNCH) begin
        r_wait_cnt <= '0;
      end else if ((r_state == S_WAIT) && (w_state_next == S_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
      if (instr_valid && !w_ready && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_exec_stall_ctrl.sv
// Scoreboard bench for exec_stall_ctrl: per-instruction expectations are queued at issue
// and checked by a monitor when the instruction retires (ready high).
module tb_exec_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [4:0]  opsel;
  logic        mem_busy;
  logic        flush;
  logic        mc_done;
  logic        ready;
  logic        mc_start;
  logic [4:0]  mc_op;
  logic        mc_cancel;
  logic        busy;
  logic        timeout_err;
  logic [15:0] stall_cnt;

  exec_stall_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .opsel       (opsel),
    .mem_busy    (mem_busy),
    .flush       (flush),
    .mc_done     (mc_done),
    .ready       (ready),
    .mc_start    (mc_start),
    .mc_op       (mc_op),
    .mc_cancel   (mc_cancel),
    .busy        (busy),
    .timeout_err (timeout_err),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    bit         is_mc;
    int         stalls;
    int         starts;
    int         cancels;
  } exp_t;

  exp_t sb[$];
  int   n_checks    = 0;
  int   n_pass      = 0;
  int   exp_total   = 0;
  int   resp_delay  = -1;
  int   mon_stalls  = 0;
  int   mon_starts  = 0;
  int   mon_cancels = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Iterative-unit model: answers mc_start after resp_delay cycles (negative = never).
  initial begin
    mc_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && mc_start && resp_delay >= 0) begin
        repeat (resp_delay) @(posedge clk);
        #1 mc_done = 1'b1;
        @(posedge clk);
        #1 mc_done = 1'b0;
      end
    end
  end

  // Retirement monitor.
  always @(negedge clk) begin
    if (!rst || !instr_valid) begin
      mon_stalls  = 0;
      mon_starts  = 0;
      mon_cancels = 0;
    end else begin
      if (mc_start) mon_starts++;
      if (mc_cancel) mon_cancels++;
      if (ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_empty", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("retire op=%0d stalls=%0d starts=%0d cancels=%0d stall_cnt=%0d",
                   e.op, mon_stalls, mon_starts, mon_cancels, stall_cnt);
          check_eq("stalls", mon_stalls, e.stalls);
          check_eq("starts", mon_starts, e.starts);
          check_eq("cancels", mon_cancels, e.cancels);
          check_eq("busy_at_retire", busy, e.is_mc);
          check_eq("stall_cnt", stall_cnt, exp_total);
          if (e.is_mc) check_eq("mc_op", mc_op, e.op);
        end
        mon_stalls  = 0;
        mon_starts  = 0;
        mon_cancels = 0;
      end else begin
        mon_stalls++;
      end
    end
  end

  task automatic issue(input logic [4:0] op, input bit is_mc, input int delay,
                       input int busy_cyc, input int exp_stalls, input int exp_cancels);
    exp_t e;
    int   n;
    bit   done;
    e.op = op; e.is_mc = is_mc; e.stalls = exp_stalls;
    e.starts = is_mc ? 1 : 0; e.cancels = exp_cancels;
    sb.push_back(e);
    exp_total += exp_stalls;
    resp_delay = delay;
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    opsel       = op;
    mem_busy    = (busy_cyc > 0);
    n = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      if (ready) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        n++;
        mem_busy = (n < busy_cyc);
      end
    end
    if (!done) check_eq("retire_timeout", 0, 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    opsel       = 5'd0;
    mem_busy    = 1'b0;
    @(negedge clk);
    check_eq("post_ready", ready, 0);
    check_eq("post_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b0; instr_valid = 1'b1; opsel = 5'd0; mem_busy = 1'b0; flush = 1'b0;
    #12;
    check_eq("rst_ready", ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_start", mc_start, 0);
    check_eq("rst_cancel", mc_cancel, 0);
    check_eq("rst_mc_op", mc_op, 0);
    check_eq("rst_terr", timeout_err, 0);
    check_eq("rst_stall", stall_cnt, 0);
    instr_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    issue(5'd0,  1'b0, -1, 0, 0, 0);    // ADD retires at once
    issue(5'd8,  1'b1,  4, 0, 6, 0);    // MUL, done 4 cycles after start
    issue(5'd1,  1'b0, -1, 3, 3, 0);    // single-cycle op held by mem_busy
    issue(5'd9,  1'b1, -1, 0, 66, 1);   // DIV never answers: timeout
    check_eq("terr_set", timeout_err, 1);
    issue(5'd10, 1'b1,  1, 0, 3, 0);    // modulo op at minimum latency
    check_eq("terr_sticky", timeout_err, 1);

    // POW flushed in WAIT; the late mc_done lands while IDLE.
    resp_delay = 5;
    @(posedge clk);
    #1 instr_valid = 1'b1; opsel = 5'd11;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check_eq("flush_cancel", mc_cancel, 1);
    check_eq("flush_ready", ready, 0);
    check_eq("flush_busy", busy, 1);
    @(posedge clk);
    #1 flush = 1'b0; instr_valid = 1'b0; opsel = 5'd0;
    exp_total += 5;
    @(negedge clk);
    check_eq("flush_idle", busy, 0);
    check_eq("flush_cancel_1cyc", mc_cancel, 0);
    check_eq("flush_stall_cnt", stall_cnt, exp_total);
    @(negedge clk);
    check_eq("late_done_seen", mc_done, 1);
    check_eq("late_done_busy", busy, 0);
    check_eq("late_done_start", mc_start, 0);
    check_eq("late_done_ready", ready, 0);
    @(negedge clk);
    check_eq("late_done_busy2", busy, 0);

    // Async reset in the middle of WAIT.
    resp_delay = -1;
    @(posedge clk);
    #1 instr_valid = 1'b1; opsel = 5'd8;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", ready, 0);
    check_eq("mid_rst_start", mc_start, 0);
    check_eq("mid_rst_cancel", mc_cancel, 0);
    check_eq("mid_rst_terr", timeout_err, 0);
    check_eq("mid_rst_stall", stall_cnt, 0);
    exp_total = 0;
    @(posedge clk);
    #1 instr_valid = 1'b0; opsel = 5'd0;
    @(posedge clk);
    #1 rst = 1'b1;

    issue(5'd12, 1'b1, 2, 0, 4, 0);     // RAD after reset
    check_eq("terr_after_rst", timeout_err, 0);
    check_eq("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_stall_ctrl.md
Name: exec_stall_ctrl

Overview:
Sequences multi-cycle ALU operations (MUL, DIV, MOD, POW, RAD) and data-memory wait states for the single-issue core. Generates the `ready` qualifier that the control unit uses to gate PC load, register/ACC/flag writes and memory writes. Launches the iterative arithmetic unit through a start/done handshake, bounds it with a timeout, and supports a flush abort. Keeps a saturating stall-cycle counter for debug.

Parameters:
OP_MUL, 5'd8, opsel code of multiply (multi-cycle)
OP_DIV, 5'd9, opsel code of divide (multi-cycle)
OP_MOD, 5'd10, opsel code of modulo (multi-cycle)
OP_POW, 5'd11, opsel code of power (multi-cycle)
OP_RAD, 5'd12, opsel code of root (multi-cycle)
TIMEOUT, 64, max WAIT cycles before forced completion (>=2)
STALL_W, 16, width of stall-cycle counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
instr_valid  in  1  high from the first cycle a new instruction is presented until it retires
opsel  in  5  ALU op select from control unit for the current instruction
mem_busy  in  1  data memory not ready this cycle
flush  in  1  synchronous abort of any in-flight multi-cycle op
mc_done  in  1  iterative unit result valid (single-cycle pulse)
ready  out  1  combinational: current instruction may commit this cycle
mc_start  out  1  one-cycle launch pulse to iterative unit
mc_op  out  5  latched opsel for iterative unit, stable from LAUNCH to DONE
mc_cancel  out  1  one-cycle pulse: iterative unit must abandon current op
busy  out  1  state != IDLE
timeout_err  out  1  sticky; set on timeout, cleared only by reset
stall_cnt  out  STALL_W  saturating count of cycles with instr_valid=1 and ready=0

Behaviour:
- mc_hit = instr_valid & (opsel in {OP_MUL, OP_DIV, OP_MOD, OP_POW, OP_RAD}).
- Reset (rst=0, async): state=IDLE, mc_op=0, wait counter=0, timeout_err=0, stall_cnt=0. All outputs 0 (ready=0).
- States:
  - IDLE:
    - ready = instr_valid & ~mc_hit & ~mem_busy.
    - If mc_hit & ~flush: latch mc_op <= opsel, go to LAUNCH.
  - LAUNCH:
    - mc_start=1, ready=0, wait counter cleared, go to WAIT.
  - WAIT:
    - ready=0, counter increments each cycle.
    - mc_done=1: go to DONE.
    - Otherwise, counter==TIMEOUT-1: set timeout_err, pulse mc_cancel, go to DONE.
  - DONE:
    - ready=1 for exactly one cycle, so the ALU result is written to ACC/flags.
    - Go to IDLE. The next instruction arrives in the following cycle.
- Multi-cycle latency: minimum 3 cycles from first cycle of mc_hit to ready (IDLE, LAUNCH, WAIT with immediate done, then DONE).
  - mc_done is sampled only in WAIT. mc_done in any other state is ignored.
- mem_busy only affects ready in IDLE. Multi-cycle ALU ops do not access data memory.
- flush has priority over every transition. From LAUNCH, WAIT or DONE it goes to IDLE on the next edge.
  - Pulse mc_cancel if leaving LAUNCH or WAIT.
  - ready=0 in the flush cycle for all states except IDLE, where the IDLE ready equation still holds.
- mc_done and timeout in the same cycle: done wins, timeout_err is not set.
- The wait counter is $clog2(TIMEOUT) bits and never wraps: the timeout exits WAIT first.
- stall_cnt increments when instr_valid & ~ready, and saturates at all-ones.
- Async reset mid-operation drops mc_start/mc_cancel immediately. No cancel pulse is issued. The iterative unit is reset by the same rst.

Test Plan:
- Reset then instr_valid=1, opsel=ADD(0), mem_busy=0 -> ready=1 in same cycle; busy=0; stall_cnt stays 0.
- Assert rst low mid-WAIT -> state IDLE immediately, ready=0, mc_start=0, mc_cancel=0, timeout_err=0, stall_cnt=0.
- opsel=OP_MUL, mc_done pulsed 4 cycles after mc_start -> mc_start high exactly 1 cycle, mc_op=8 held, ready high exactly 1 cycle (DONE), stall_cnt=6.
- opsel=OP_DIV, mc_done never asserted, TIMEOUT=64 -> mc_cancel pulse after 64 WAIT cycles, ready=1 the next cycle, timeout_err=1 persists through later instructions.
- Single-cycle op with mem_busy=1 for 3 cycles -> ready=0 for 3 cycles, then 1; stall_cnt +3; no mc_start.
- OP_POW in WAIT, flush=1 -> next cycle IDLE, mc_cancel=1 for one cycle, ready never asserted for that op; mc_done arriving in IDLE is ignored.
